// File: rtl/gps_ack_multi.sv
// Multi-channel serial-search GPS C/A acquisition correlator: one shared G1/G2 pair,
// per-channel G2 phase taps, per-hypothesis |I|+|Q| with per-channel peak hold.
module gps_ack_multi #(
  parameter int          NCH       = 4,
  parameter int          SAMPLE_W  = 1,
  parameter int          ACC_W     = 16,
  parameter int          INT_LEN   = 4000,
  parameter int          PHASES    = 1023,
  parameter logic [31:0] CODE_STEP = 32'd1098437886
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ack_start,
  input  logic                 adc_clk,
  input  logic [SAMPLE_W-1:0]  i_sample,
  input  logic [SAMPLE_W-1:0]  q_sample,
  input  logic [NCH*5-1:0]     sat,
  output logic                 busy,
  output logic                 int_active,
  output logic                 corr_complete,
  output logic [9:0]           code_phase,
  output logic [NCH*ACC_W-1:0] integrator,
  output logic [NCH*10-1:0]    peak_phase,
  output logic [NCH*ACC_W-1:0] peak_mag,
  output logic                 done
);

  localparam int CNT_W = $clog2(INT_LEN + 1);

  typedef enum logic [2:0] {IDLE, SLEW, ARM, INTEGRATE, DUMP, DONE} state_t;
  state_t state, state_n;

  logic [10:1]             g1, g2, g1_adv, g2_adv;
  logic [31:0]             nco;
  logic [32:0]             nco_sum;
  logic [9:0]              phase, slew_cnt;
  logic [CNT_W-1:0]        samp_cnt;
  logic [NCH*5-1:0]        sat_q;
  logic                    adc_prev, strobe, accept, last;
  logic signed [ACC_W-1:0] acc_i [NCH];
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] si, sq;
  logic [ACC_W-1:0]        mag [NCH];
  logic [NCH-1:0]          chip, en;

  // IS-GPS-200 G2 phase-selector taps; the 5-bit field reaches PRN 1..31, 0 disables.
  function automatic logic [7:0] tap_pair(input logic [4:0] prn);
    case (prn)
      5'd1:  return {4'd2, 4'd6};   5'd2:  return {4'd3, 4'd7};
      5'd3:  return {4'd4, 4'd8};   5'd4:  return {4'd5, 4'd9};
      5'd5:  return {4'd1, 4'd9};   5'd6:  return {4'd2, 4'd10};
      5'd7:  return {4'd1, 4'd8};   5'd8:  return {4'd2, 4'd9};
      5'd9:  return {4'd3, 4'd10};  5'd10: return {4'd2, 4'd3};
      5'd11: return {4'd3, 4'd4};   5'd12: return {4'd5, 4'd6};
      5'd13: return {4'd6, 4'd7};   5'd14: return {4'd7, 4'd8};
      5'd15: return {4'd8, 4'd9};   5'd16: return {4'd9, 4'd10};
      5'd17: return {4'd1, 4'd4};   5'd18: return {4'd2, 4'd5};
      5'd19: return {4'd3, 4'd6};   5'd20: return {4'd4, 4'd7};
      5'd21: return {4'd5, 4'd8};   5'd22: return {4'd6, 4'd9};
      5'd23: return {4'd1, 4'd3};   5'd24: return {4'd4, 4'd6};
      5'd25: return {4'd5, 4'd7};   5'd26: return {4'd6, 4'd8};
      5'd27: return {4'd7, 4'd9};   5'd28: return {4'd8, 4'd10};
      5'd29: return {4'd1, 4'd6};   5'd30: return {4'd2, 4'd7};
      5'd31: return {4'd3, 4'd8};
      default: return {4'd1, 4'd1};
    endcase
  endfunction

  function automatic logic signed [ACC_W-1:0] sample_val(input logic [SAMPLE_W-1:0] s);
    logic signed [ACC_W-1:0] v;
    if (SAMPLE_W == 1) v = s[0] ? ACC_W'(1) : {ACC_W{1'b1}};
    else               v = ACC_W'(signed'(s));
    return v;
  endfunction

  assign si      = sample_val(i_sample);
  assign sq      = sample_val(q_sample);
  assign g1_adv  = {g1[9:1], g1[3] ^ g1[10]};
  assign g2_adv  = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
  assign nco_sum = {1'b0, nco} + {1'b0, CODE_STEP};
  assign strobe  = adc_clk & ~adc_prev;
  assign accept  = strobe && (state == ARM || state == INTEGRATE);
  assign last    = (samp_cnt == CNT_W'(INT_LEN - 1));

  always_comb begin
    logic [7:0] tp;
    tp   = '0;
    chip = '0;
    en   = '0;
    for (int c = 0; c < NCH; c++) begin
      tp      = tap_pair(sat_q[c*5 +: 5]);
      chip[c] = g1[10] ^ g2[tp[7:4]] ^ g2[tp[3:0]];
      en[c]   = |sat_q[c*5 +: 5];
    end
  end

  // |I|+|Q| clamped at all-ones; the most negative accumulator still fits unsigned.
  always_comb begin
    logic [ACC_W-1:0] ai, aq;
    logic [ACC_W:0]   s;
    ai = '0;
    aq = '0;
    s  = '0;
    for (int c = 0; c < NCH; c++) begin
      ai     = acc_i[c][ACC_W-1] ? unsigned'(-acc_i[c]) : unsigned'(acc_i[c]);
      aq     = acc_q[c][ACC_W-1] ? unsigned'(-acc_q[c]) : unsigned'(acc_q[c]);
      s      = {1'b0, ai} + {1'b0, aq};
      mag[c] = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (ack_start) state_n = SLEW;
      SLEW:      if (phase == 10'd0 || slew_cnt == phase - 10'd1) state_n = ARM;
      ARM:       if (accept) state_n = last ? DUMP : INTEGRATE;
      INTEGRATE: if (accept && last) state_n = DUMP;
      DUMP:      state_n = (phase == 10'(PHASES - 1)) ? DONE : SLEW;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      g1            <= '1;
      g2            <= '1;
      nco           <= '0;
      phase         <= '0;
      slew_cnt      <= '0;
      samp_cnt      <= '0;
      sat_q         <= '0;
      adc_prev      <= 1'b0;
      busy          <= 1'b0;
      int_active    <= 1'b0;
      corr_complete <= 1'b0;
      code_phase    <= '0;
      integrator    <= '0;
      peak_phase    <= '0;
      peak_mag      <= '0;
      done          <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        acc_i[c] <= '0;
        acc_q[c] <= '0;
      end
    end else begin
      state         <= state_n;
      adc_prev      <= adc_clk;
      corr_complete <= 1'b0;
      done          <= 1'b0;
      int_active    <= (state_n == INTEGRATE);
      case (state)
        IDLE: if (ack_start) begin
          sat_q      <= sat;
          phase      <= '0;
          busy       <= 1'b1;
          code_phase <= '0;
          integrator <= '0;
          peak_phase <= '0;
          peak_mag   <= '0;
          g1         <= '1;
          g2         <= '1;
          nco        <= '0;
          slew_cnt   <= '0;
          samp_cnt   <= '0;
          for (int c = 0; c < NCH; c++) begin
            acc_i[c] <= '0;
            acc_q[c] <= '0;
          end
        end
        SLEW: if (phase != 10'd0) begin
          g1       <= g1_adv;
          g2       <= g2_adv;
          slew_cnt <= slew_cnt + 10'd1;
        end
        ARM, INTEGRATE: if (accept) begin
          for (int c = 0; c < NCH; c++) begin
            acc_i[c] <= chip[c] ? acc_i[c] + si : acc_i[c] - si;
            acc_q[c] <= chip[c] ? acc_q[c] + sq : acc_q[c] - sq;
          end
          samp_cnt <= samp_cnt + CNT_W'(1);
          nco      <= nco_sum[31:0];
          if (nco_sum[32]) begin
            g1 <= g1_adv;
            g2 <= g2_adv;
          end
        end
        DUMP: begin
          corr_complete <= 1'b1;
          code_phase    <= phase;
          for (int c = 0; c < NCH; c++) begin
            if (en[c]) begin
              integrator[c*ACC_W +: ACC_W] <= mag[c];
              if (mag[c] > peak_mag[c*ACC_W +: ACC_W]) begin
                peak_mag[c*ACC_W +: ACC_W] <= mag[c];
                peak_phase[c*10 +: 10]     <= phase;
              end
            end else begin
              integrator[c*ACC_W +: ACC_W] <= '0;
              peak_mag[c*ACC_W +: ACC_W]   <= '0;
              peak_phase[c*10 +: 10]       <= '0;
            end
            acc_i[c] <= '0;
            acc_q[c] <= '0;
          end
          // Prepare the next slew from the code epoch.
          samp_cnt <= '0;
          g1       <= '1;
          g2       <= '1;
          nco      <= '0;
          slew_cnt <= '0;
          phase    <= phase + 10'd1;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gps_ack_multi.sv
// Bench for gps_ack_multi: two configurations, directed searches, a delay-table PRN model
// and an expected-result queue popped on every corr_complete.
module tb_gps_ack_multi;

  localparam int          A_NCH  = 2;
  localparam int          A_ACC  = 16;
  localparam int          A_INT  = 64;
  localparam int          A_PH   = 8;
  localparam logic [31:0] A_STEP = 32'h4000_0000;
  localparam int          A_W    = 10 + A_NCH * A_ACC;

  localparam int          B_ACC  = 6;
  localparam int          B_INT  = 8;
  localparam int          B_PH   = 3;
  localparam logic [31:0] B_STEP = 32'h8000_0000;
  localparam int          B_W    = 10 + B_ACC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   ack_a, adc_a, busy_a, int_a, cc_a, done_a;
  logic [0:0]             i_a, q_a;
  logic [A_NCH*5-1:0]     sat_a;
  logic [9:0]             cp_a;
  logic [A_NCH*A_ACC-1:0] integ_a, pm_a;
  logic [A_NCH*10-1:0]    pp_a;

  logic                   ack_b, adc_b, busy_b, int_b, cc_b, done_b;
  logic [1:0]             i_b, q_b;
  logic [4:0]             sat_b;
  logic [9:0]             cp_b, pp_b;
  logic [B_ACC-1:0]       integ_b, pm_b;

  gps_ack_multi #(.NCH(A_NCH), .SAMPLE_W(1), .ACC_W(A_ACC), .INT_LEN(A_INT),
                  .PHASES(A_PH), .CODE_STEP(A_STEP)) dut_a (
    .clk(clk), .rst(rst), .ack_start(ack_a), .adc_clk(adc_a), .i_sample(i_a),
    .q_sample(q_a), .sat(sat_a), .busy(busy_a), .int_active(int_a),
    .corr_complete(cc_a), .code_phase(cp_a), .integrator(integ_a),
    .peak_phase(pp_a), .peak_mag(pm_a), .done(done_a));

  gps_ack_multi #(.NCH(1), .SAMPLE_W(2), .ACC_W(B_ACC), .INT_LEN(B_INT),
                  .PHASES(B_PH), .CODE_STEP(B_STEP)) dut_b (
    .clk(clk), .rst(rst), .ack_start(ack_b), .adc_clk(adc_b), .i_sample(i_b),
    .q_sample(q_b), .sat(sat_b), .busy(busy_b), .int_active(int_b),
    .corr_complete(cc_b), .code_phase(cp_b), .integrator(integ_b),
    .peak_phase(pp_b), .peak_mag(pm_b), .done(done_b));

  int checks = 0;
  int errors = 0;

  bit g1s [1023];
  bit g2s [1023];
  int g2_delay [32] = '{0, 5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257,
                        258, 469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516,
                        859, 860, 861};

  logic [A_W-1:0] exp_q [$];
  logic [B_W-1:0] exp_b_q [$];
  logic [A_W-1:0] last_exp_a, e_a_mon;
  logic [B_W-1:0] e_b_mon;
  int cc_a_cnt = 0, done_a_cnt = 0, cc_b_cnt = 0, done_b_cnt = 0, done_b_cc = -1;
  int pk_mag_a [A_NCH];
  int pk_ph_a  [A_NCH];
  int pk_mag_b, pk_ph_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference code: G1 xor G2 delayed by the per-PRN chip delay.
  task automatic build_codes();
    bit [10:1] r1, r2;
    r1 = '1;
    r2 = '1;
    for (int n = 0; n < 1023; n++) begin
      g1s[n] = r1[10];
      g2s[n] = r2[10];
      r1 = {r1[9:1], r1[3] ^ r1[10]};
      r2 = {r2[9:1], r2[2] ^ r2[3] ^ r2[6] ^ r2[8] ^ r2[9] ^ r2[10]};
    end
  endtask

  function automatic bit prn_chip(input int prn, input int n);
    int m;
    m = n % 1023;
    return g1s[m] ^ g2s[(m - g2_delay[prn] + 1023) % 1023];
  endfunction

  function automatic bit a_bit_i(input int k, input int mode);
    return (mode == 0) ? prn_chip(1, 5 + k / 4) : 1'b1;
  endfunction

  function automatic bit a_bit_q(input int k, input int mode);
    return (mode == 0) ? prn_chip(1, 5 + k / 4) : 1'b0;
  endfunction

  function automatic int clamp_mag(input int ii, input int qq, input int accw);
    int m;
    m = (ii < 0 ? -ii : ii) + (qq < 0 ? -qq : qq);
    return (m > (1 << accw) - 1) ? (1 << accw) - 1 : m;
  endfunction

  task automatic build_exp_a(input int p, input int mode, output logic [A_W-1:0] e);
    int prn, ii, qq, m, idx;
    e = '0;
    e[A_W-1 -: 10] = p[9:0];
    for (int c = 0; c < A_NCH; c++) begin
      prn = int'(sat_a[c*5 +: 5]);
      m = 0;
      if (prn != 0) begin
        ii = 0;
        qq = 0;
        for (int k = 0; k < A_INT; k++) begin
          idx = p + int'((longint'(k) * longint'(A_STEP)) >> 32);
          ii += (a_bit_i(k, mode) ? 1 : -1) * (prn_chip(prn, idx) ? 1 : -1);
          qq += (a_bit_q(k, mode) ? 1 : -1) * (prn_chip(prn, idx) ? 1 : -1);
        end
        m = clamp_mag(ii, qq, A_ACC);
      end
      e[c*A_ACC +: A_ACC] = m[A_ACC-1:0];
      if (m > pk_mag_a[c]) begin
        pk_mag_a[c] = m;
        pk_ph_a[c]  = p;
      end
    end
  endtask

  task automatic pulse_ack_a();
    @(negedge clk) ack_a = 1'b1;
    @(negedge clk) ack_a = 1'b0;
  endtask

  task automatic drive_samples_a(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_a   = a_bit_i(k, mode);
      q_a   = a_bit_q(k, mode);
      adc_a = 1'b1;
      @(negedge clk) adc_a = 1'b0;
    end
  endtask

  task automatic run_window_a(input int p, input int mode);
    logic [A_W-1:0] e;
    build_exp_a(p, mode, e);
    exp_q.push_back(e);
    last_exp_a = e;
    repeat (p + 4) @(negedge clk);
    drive_samples_a(A_INT, mode);
  endtask

  task automatic wait_done_a(input int d0);
    for (int t = 0; t < 200 && done_a_cnt == d0; t++) @(negedge clk);
    check("a_done_once", done_a_cnt - d0, 1);
  endtask

  task automatic run_search_a(input int mode);
    int d0, c0;
    d0 = done_a_cnt;
    c0 = cc_a_cnt;
    for (int c = 0; c < A_NCH; c++) begin
      pk_mag_a[c] = 0;
      pk_ph_a[c]  = 0;
    end
    pulse_ack_a();
    for (int p = 0; p < A_PH; p++) run_window_a(p, mode);
    wait_done_a(d0);
    @(negedge clk);
    check("a_busy_after_done", busy_a, 0);
    check("a_cc_count", cc_a_cnt - c0, A_PH);
    for (int c = 0; c < A_NCH; c++) begin
      check($sformatf("a_peak_mag_ch%0d", c), pm_a[c*A_ACC +: A_ACC], pk_mag_a[c]);
      check($sformatf("a_peak_phase_ch%0d", c), pp_a[c*10 +: 10], pk_ph_a[c]);
    end
  endtask

  task automatic run_window_b(input int p);
    logic [B_W-1:0] e;
    int ii, idx, m;
    ii = 0;
    for (int k = 0; k < B_INT; k++) begin
      idx = p + int'((longint'(k) * longint'(B_STEP)) >> 32);
      ii += -2 * (prn_chip(1, idx) ? 1 : -1);
    end
    m = clamp_mag(ii, ii, B_ACC);
    if (m > pk_mag_b) begin
      pk_mag_b = m;
      pk_ph_b  = p;
    end
    e = {p[9:0], m[B_ACC-1:0]};
    exp_b_q.push_back(e);
    repeat (p + 4) @(negedge clk);
    // A start request while the search is running must be ignored.
    if (p == 1) begin
      ack_b = 1'b1;
      @(negedge clk) ack_b = 1'b0;
    end
    for (int k = 0; k < B_INT; k++) begin
      @(negedge clk);
      i_b   = 2'b10;
      q_b   = 2'b10;
      adc_b = 1'b1;
      @(negedge clk) adc_b = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (cc_a) begin
      cc_a_cnt++;
      check("a_cc_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e_a_mon = exp_q.pop_front();
        check("a_code_phase", cp_a, e_a_mon[A_W-1 -: 10]);
        check("a_integrator", integ_a, e_a_mon[A_NCH*A_ACC-1:0]);
      end
    end
    if (done_a) done_a_cnt++;
    if (cc_b) begin
      cc_b_cnt++;
      check("b_cc_expected", exp_b_q.size() > 0, 1);
      if (exp_b_q.size() > 0) begin
        e_b_mon = exp_b_q.pop_front();
        check("b_code_phase", cp_b, e_b_mon[B_W-1 -: 10]);
        check("b_integrator", integ_b, e_b_mon[B_ACC-1:0]);
      end
    end
    if (done_b) begin
      done_b_cnt++;
      done_b_cc = cc_b_cnt;
    end
  end

  initial begin
    int d0, c0;
    build_codes();
    rst = 1'b1;
    ack_a = 1'b0; adc_a = 1'b0; i_a = '0; q_a = '0; sat_a = '0;
    ack_b = 1'b0; adc_b = 1'b0; i_b = '0; q_b = '0; sat_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {busy_a, busy_b}, 0);
    check("rst_int_active", {int_a, int_b}, 0);
    check("rst_pulses", {cc_a, done_a, cc_b, done_b}, 0);
    check("rst_code_phase", {cp_a, cp_b}, 0);
    check("rst_integrator", {integ_a, integ_b}, 0);
    check("rst_peaks", {pp_a, pm_a, pp_b, pm_b}, 0);
    rst = 1'b0;

    // 2-bit samples, constant -2 on I and Q, PRN1, 2 samples per chip.
    sat_b = 5'd1;
    pk_mag_b = 0;
    pk_ph_b  = 0;
    @(negedge clk) ack_b = 1'b1;
    @(negedge clk) ack_b = 1'b0;
    check("b_busy_after_start", busy_b, 1);
    for (int p = 0; p < B_PH; p++) run_window_b(p);
    for (int t = 0; t < 200 && done_b_cnt == 0; t++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("b_done_count", done_b_cnt, 1);
    check("b_cc_before_done", done_b_cc, B_PH);
    check("b_cc_count", cc_b_cnt, B_PH);
    check("b_busy_idle", busy_b, 0);
    check("b_peak_mag", pm_b, pk_mag_b);
    check("b_peak_phase", pp_b, pk_ph_b);

    // PRN1 replica advanced 5 chips on I and Q; channel 1 searches PRN7.
    sat_a = {5'd7, 5'd1};
    run_search_a(0);
    check("a_replica_peak_phase", pp_a[9:0], 5);
    check("a_replica_peak_mag", pm_a[A_ACC-1:0], 2 * A_INT);
    repeat (6) @(negedge clk);
    check("a_hold_integrator", integ_a, last_exp_a[A_NCH*A_ACC-1:0]);
    check("a_hold_code_phase", cp_a, A_PH - 1);

    // Channel 1 disabled; constant i=1, q=0 on channel 0.
    sat_a = {5'd0, 5'd1};
    run_search_a(1);
    check("a_dis_integrator", integ_a[2*A_ACC-1:A_ACC], 0);
    check("a_dis_peak_mag", pm_a[2*A_ACC-1:A_ACC], 0);
    check("a_dis_peak_phase", pp_a[19:10], 0);

    // Reset during the p=5 integration aborts without a done pulse.
    sat_a = {5'd7, 5'd1};
    d0 = done_a_cnt;
    c0 = cc_a_cnt;
    for (int c = 0; c < A_NCH; c++) begin
      pk_mag_a[c] = 0;
      pk_ph_a[c]  = 0;
    end
    pulse_ack_a();
    for (int p = 0; p < 5; p++) run_window_a(p, 0);
    repeat (9) @(negedge clk);
    drive_samples_a(10, 0);
    check("a_int_active_mid", int_a, 1);
    rst = 1'b1;
    @(negedge clk);
    check("a_rst_mid_busy", busy_a, 0);
    check("a_rst_mid_outputs", {int_a, cc_a, done_a, cp_a}, 0);
    check("a_rst_mid_results", {integ_a, pp_a, pm_a}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("a_rst_mid_no_done", done_a_cnt - d0, 0);
    check("a_rst_mid_cc_count", cc_a_cnt - c0, 5);
    check("a_rst_mid_queue", exp_q.size(), 0);
    check("a_rst_mid_still_idle", busy_a, 0);

    run_search_a(0);
    check("a_restart_peak_phase", pp_a[9:0], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
